// File: rtl/sfp_test_pkg.sv
// Shared definitions for the SFP loopback test path (frame generator and checker).
// Holds the checker FSM state type, CRC-32 constants, the preamble/SFD bytes and the
// EtherType used by the generated test frames.
package sfp_test_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPreamble = 2'd1,
        StData     = 2'd2,
        StDrop     = 2'd3
    } chk_state_t;

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    // Bit-reversed form of CRC32_POLY, used by the LSB-first shift register.
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Register value left after clocking a frame plus its own valid FCS through the CRC.
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;

    localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h88B5;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB first).
// Ports:
//   crc_i  - current CRC register
//   data_i - byte to absorb, bit 0 first
//   crc_o  - CRC register after absorbing data_i (no final inversion)
module crc32_d8
    import sfp_test_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc_i;
        for (int b = 0; b < 8; b++) begin
            if (crc_o[0] ^ data_i[b]) begin
                crc_o = (crc_o >> 1) ^ CRC32_POLY_REFL;
            end else begin
                crc_o = crc_o >> 1;
            end
        end
    end

endmodule

// File: rtl/gmii_frame_checker.sv
// Receive-side checker for frames returned through the SGMII loopback path.
// Strips preamble/SFD, then checks frame length, CRC-32 FCS, EtherType and the
// incrementing payload pattern written by the test-frame generator. One result per
// frame is reported as a pulse plus saturating per-class statistics counters.
// Ports:
//   clk_125_lvds, rst_n            - GMII clock, async active-low reset
//   gmii_rx_dv/gmii_rx_er/gmii_rxd - GMII receive interface
//   clear_cnt                      - synchronous clear of all statistics counters
//   frame_done/frame_ok            - end-of-frame pulse and its pass/fail result
//   last_seq                       - sequence byte (frame byte 14) of last frame
//   good_cnt/crc_err_cnt/len_err_cnt/pat_err_cnt - per-class frame counters
module gmii_frame_checker
    import sfp_test_pkg::*;
#(
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518,
    parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_125_lvds,
    input  logic             rst_n,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    input  logic             clear_cnt,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [7:0]       last_seq,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] crc_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic [CNT_W-1:0] pat_err_cnt
);

    chk_state_t        state_q, state_d;
    logic [31:0]       crc_q, crc_d, crc_next;
    logic [10:0]       len_q, len_d;
    logic [3:0][7:0]   dly_q, dly_d;
    logic [7:0]        seq_q, seq_d;
    logic              pat_err_q, pat_err_d;
    logic              phy_err_q, phy_err_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_ok_q, frame_ok_d;
    logic [7:0]        last_seq_q, last_seq_d;
    logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]  crc_err_cnt_q, crc_err_cnt_d;
    logic [CNT_W-1:0]  len_err_cnt_q, len_err_cnt_d;
    logic [CNT_W-1:0]  pat_err_cnt_q, pat_err_cnt_d;

    logic              start_frame;
    logic              inc_good, inc_crc, inc_len, inc_pat;
    logic [10:0]       chk_idx;
    logic [7:0]        chk_byte;
    logic [7:0]        exp_pat;
    logic [31:0]       len_ext;
    logic              len_bad, crc_bad;

    crc32_d8 u_crc32_d8 (
        .crc_i  (crc_q),
        .data_i (gmii_rxd),
        .crc_o  (crc_next)
    );

    // Oldest byte in the 4-deep delay line; it is byte (len_q - 4) of the frame,
    // which keeps the trailing FCS out of the pattern check.
    assign chk_idx  = len_q - 11'd4;
    assign chk_byte = dly_q[3];
    assign exp_pat  = seq_q + chk_idx[7:0] - 8'd14;
    assign len_ext  = {21'd0, len_q};
    assign len_bad  = (len_ext < MIN_LEN) || (len_ext > MAX_LEN);
    assign crc_bad  = (crc_q != CRC32_RESIDUE) || phy_err_q;

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        len_d        = len_q;
        dly_d        = dly_q;
        seq_d        = seq_q;
        pat_err_d    = pat_err_q;
        phy_err_d    = phy_err_q;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        last_seq_d   = last_seq_q;
        start_frame  = 1'b0;
        inc_good     = 1'b0;
        inc_crc      = 1'b0;
        inc_len      = 1'b0;
        inc_pat      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PREAMBLE_BYTE) begin
                        state_d = StPreamble;
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state_d     = StData;
                        start_frame = 1'b1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StPreamble: begin
                if (!gmii_rx_dv) begin
                    state_d = StIdle;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_d     = StData;
                    start_frame = 1'b1;
                end else if (gmii_rxd != PREAMBLE_BYTE) begin
                    state_d = StDrop;
                end
            end
            StData: begin
                if (gmii_rx_dv) begin
                    len_d = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
                    crc_d = crc_next;
                    dly_d = {dly_q[2:0], gmii_rxd};
                    if (gmii_rx_er) begin
                        phy_err_d = 1'b1;
                    end
                    // Sequence byte taken straight off the wire so it is available
                    // even for frames too short to push it through the delay line.
                    if (len_q == 11'd14) begin
                        seq_d = gmii_rxd;
                    end
                    if (len_q >= 11'd4) begin
                        if (chk_idx == 11'd12) begin
                            if (chk_byte != ETHERTYPE[15:8]) pat_err_d = 1'b1;
                        end else if (chk_idx == 11'd13) begin
                            if (chk_byte != ETHERTYPE[7:0]) pat_err_d = 1'b1;
                        end else if (chk_idx >= 11'd15) begin
                            if (chk_byte != exp_pat) pat_err_d = 1'b1;
                        end
                    end
                end else begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                    if (len_q >= 11'd15) begin
                        last_seq_d = seq_q;
                    end
                    if (len_bad) begin
                        inc_len = 1'b1;
                    end else if (crc_bad) begin
                        inc_crc = 1'b1;
                    end else if (pat_err_q) begin
                        inc_pat = 1'b1;
                    end else begin
                        inc_good   = 1'b1;
                        frame_ok_d = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (!gmii_rx_dv) begin
                    state_d = StIdle;
                end
            end
        endcase

        if (start_frame) begin
            crc_d     = CRC32_INIT;
            len_d     = '0;
            dly_d     = '0;
            pat_err_d = 1'b0;
            phy_err_d = 1'b0;
        end

        // Clear beats a same-cycle increment.
        good_cnt_d    = good_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        len_err_cnt_d = len_err_cnt_q;
        pat_err_cnt_d = pat_err_cnt_q;
        if (clear_cnt) begin
            good_cnt_d    = '0;
            crc_err_cnt_d = '0;
            len_err_cnt_d = '0;
            pat_err_cnt_d = '0;
        end else begin
            if (inc_good && (good_cnt_q != '1))    good_cnt_d    = good_cnt_q + CNT_W'(1);
            if (inc_crc && (crc_err_cnt_q != '1))  crc_err_cnt_d = crc_err_cnt_q + CNT_W'(1);
            if (inc_len && (len_err_cnt_q != '1))  len_err_cnt_d = len_err_cnt_q + CNT_W'(1);
            if (inc_pat && (pat_err_cnt_q != '1))  pat_err_cnt_d = pat_err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_125_lvds or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            crc_q         <= CRC32_INIT;
            len_q         <= '0;
            dly_q         <= '0;
            seq_q         <= '0;
            pat_err_q     <= 1'b0;
            phy_err_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            last_seq_q    <= '0;
            good_cnt_q    <= '0;
            crc_err_cnt_q <= '0;
            len_err_cnt_q <= '0;
            pat_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            dly_q         <= dly_d;
            seq_q         <= seq_d;
            pat_err_q     <= pat_err_d;
            phy_err_q     <= phy_err_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            last_seq_q    <= last_seq_d;
            good_cnt_q    <= good_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
            len_err_cnt_q <= len_err_cnt_d;
            pat_err_cnt_q <= pat_err_cnt_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign last_seq    = last_seq_q;
    assign good_cnt    = good_cnt_q;
    assign crc_err_cnt = crc_err_cnt_q;
    assign len_err_cnt = len_err_cnt_q;
    assign pat_err_cnt = pat_err_cnt_q;

endmodule

// File: tb/tb_gmii_frame_checker.sv
// Directed testbench for gmii_frame_checker. Frames are built in a local buffer with
// the FCS computed by the bench; each scenario task drives one or more frames on the
// falling edge and compares outputs against hand-derived values on the falling edge.
module tb_gmii_frame_checker;
    import sfp_test_pkg::*;

    logic        clk_125_lvds = 1'b0;
    logic        rst_n;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        clear_cnt;
    logic        frame_done;
    logic        frame_ok;
    logic [7:0]  last_seq;
    logic [31:0] good_cnt;
    logic [31:0] crc_err_cnt;
    logic [31:0] len_err_cnt;
    logic [31:0] pat_err_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;

    logic [7:0]  frm [0:2047];
    int          frm_len;

    always #4 clk_125_lvds = ~clk_125_lvds;

    gmii_frame_checker dut (
        .clk_125_lvds (clk_125_lvds),
        .rst_n        (rst_n),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .gmii_rxd     (gmii_rxd),
        .clear_cnt    (clear_cnt),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .last_seq     (last_seq),
        .good_cnt     (good_cnt),
        .crc_err_cnt  (crc_err_cnt),
        .len_err_cnt  (len_err_cnt),
        .pat_err_cnt  (pat_err_cnt)
    );

    always @(negedge clk_125_lvds) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) n_done++;
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Builds a generator-style frame of len bytes (DA..FCS) into frm.
    task automatic build(input int len, input logic [7:0] seq, input logic [15:0] et,
                         input int flip_idx, input logic [7:0] fcs_xor);
        logic [31:0] c;
        frm_len = len;
        for (int i = 0; i < len - 4; i++) begin
            if (i == 0)       frm[i] = 8'h02;
            else if (i < 5)   frm[i] = 8'h00;
            else if (i == 5)  frm[i] = 8'h01;
            else if (i == 6)  frm[i] = 8'h02;
            else if (i < 11)  frm[i] = 8'h00;
            else if (i == 11) frm[i] = 8'h02;
            else if (i == 12) frm[i] = et[15:8];
            else if (i == 13) frm[i] = et[7:0];
            else if (i == 14) frm[i] = seq;
            else              frm[i] = seq + 8'(i - 14);
        end
        if (flip_idx >= 0) frm[flip_idx] = frm[flip_idx] ^ 8'hFF;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) c = crc_byte(c, frm[i]);
        c = ~c;
        frm[len-4] = c[7:0];
        frm[len-3] = c[15:8];
        frm[len-2] = c[23:16];
        frm[len-1] = c[31:24] ^ fcs_xor;
    endtask

    // Called at a falling edge; returns on the falling edge where the frame result
    // (if any) is visible, after exactly one idle cycle on the wire.
    task automatic send(input int n_pre, input logic [7:0] first_pre, input int er_idx,
                        input int rst_idx, input bit clr_end);
        for (int p = 0; p < n_pre; p++) begin
            gmii_rx_dv = 1'b1;
            gmii_rxd   = (p == 0) ? first_pre : 8'h55;
            @(negedge clk_125_lvds);
        end
        gmii_rx_dv = 1'b1;
        gmii_rxd   = 8'hD5;
        @(negedge clk_125_lvds);
        for (int i = 0; i < frm_len; i++) begin
            gmii_rxd   = frm[i];
            gmii_rx_er = (i == er_idx);
            if (i == rst_idx)     rst_n = 1'b0;
            if (i == rst_idx + 3) rst_n = 1'b1;
            @(negedge clk_125_lvds);
        end
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        clear_cnt  = clr_end;
        @(negedge clk_125_lvds);
        clear_cnt  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00; clear_cnt = 1'b0;
        repeat (3) @(negedge clk_125_lvds);
        n_checks++;
        if ({frame_done, frame_ok, last_seq} !== 10'd0)
            $display("FAIL reset_flags got done=%b ok=%b seq=%h want 0", frame_done, frame_ok,
                     last_seq);
        else n_pass++;
        n_checks++;
        if ({good_cnt, crc_err_cnt, len_err_cnt, pat_err_cnt} !== 128'd0)
            $display("FAIL reset_cnts got %0d %0d %0d %0d want all 0", good_cnt, crc_err_cnt,
                     len_err_cnt, pat_err_cnt);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk_125_lvds);
    endtask

    task automatic test_good;
        build(64, 8'h10, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (frame_done !== 1'b1 || frame_ok !== 1'b1)
            $display("FAIL good_done got done=%b ok=%b want 1 1", frame_done, frame_ok);
        else n_pass++;
        n_checks++;
        if (good_cnt !== 32'd1) $display("FAIL good_cnt got %0d want 1", good_cnt);
        else n_pass++;
        n_checks++;
        if (last_seq !== 8'h10) $display("FAIL good_seq got %h want 10", last_seq);
        else n_pass++;
        @(negedge clk_125_lvds);
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL done_pulse got %b want 0", frame_done);
        else n_pass++;
    endtask

    task automatic test_crc;
        build(64, 8'h10, 16'h88B5, -1, 8'h01);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (frame_done !== 1'b1 || frame_ok !== 1'b0)
            $display("FAIL crc_done got done=%b ok=%b want 1 0", frame_done, frame_ok);
        else n_pass++;
        n_checks++;
        if (crc_err_cnt !== 32'd1 || good_cnt !== 32'd1)
            $display("FAIL crc_cnt got crc=%0d good=%0d want 1 1", crc_err_cnt, good_cnt);
        else n_pass++;
    endtask

    task automatic test_len;
        build(60, 8'h20, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (len_err_cnt !== 32'd1 || frame_ok !== 1'b0)
            $display("FAIL len_short got len=%0d ok=%b want 1 0", len_err_cnt, frame_ok);
        else n_pass++;
        n_checks++;
        if (last_seq !== 8'h20) $display("FAIL len_seq got %h want 20", last_seq);
        else n_pass++;
        build(1519, 8'h30, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (len_err_cnt !== 32'd2) $display("FAIL len_long got %0d want 2", len_err_cnt);
        else n_pass++;
        build(1519, 8'h30, 16'h88B5, -1, 8'h80);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (len_err_cnt !== 32'd3 || crc_err_cnt !== 32'd1)
            $display("FAIL len_prio got len=%0d crc=%0d want 3 1", len_err_cnt, crc_err_cnt);
        else n_pass++;
        build(1518, 8'h40, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (good_cnt !== 32'd2 || frame_ok !== 1'b1)
            $display("FAIL len_max got good=%0d ok=%b want 2 1", good_cnt, frame_ok);
        else n_pass++;
    endtask

    task automatic test_pattern;
        build(64, 8'h10, 16'h88B5, 40, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (pat_err_cnt !== 32'd1 || frame_ok !== 1'b0)
            $display("FAIL pat_payload got pat=%0d ok=%b want 1 0", pat_err_cnt, frame_ok);
        else n_pass++;
        build(64, 8'h10, 16'h0800, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (pat_err_cnt !== 32'd2) $display("FAIL pat_etype got %0d want 2", pat_err_cnt);
        else n_pass++;
    endtask

    task automatic test_rx_er;
        build(64, 8'h10, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, 30, -1, 1'b0);
        n_checks++;
        if (crc_err_cnt !== 32'd2 || frame_ok !== 1'b0)
            $display("FAIL rx_er got crc=%0d ok=%b want 2 0", crc_err_cnt, frame_ok);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        build(64, 8'h50, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (frame_ok !== 1'b1 || last_seq !== 8'h50)
            $display("FAIL b2b_first got ok=%b seq=%h want 1 50", frame_ok, last_seq);
        else n_pass++;
        build(64, 8'h51, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (frame_ok !== 1'b1 || good_cnt !== 32'd4)
            $display("FAIL b2b_second got ok=%b good=%0d want 1 4", frame_ok, good_cnt);
        else n_pass++;
        // Zero-length preamble: SFD directly after idle.
        build(64, 8'h60, 16'h88B5, -1, 8'h00);
        send(0, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (good_cnt !== 32'd5 || last_seq !== 8'h60)
            $display("FAIL no_preamble got good=%0d seq=%h want 5 60", good_cnt, last_seq);
        else n_pass++;
    endtask

    task automatic test_bad_preamble;
        int nd0;
        @(negedge clk_125_lvds);
        nd0 = n_done;
        build(64, 8'h70, 16'h88B5, -1, 8'h00);
        send(7, 8'h5A, -1, -1, 1'b0);
        repeat (2) @(negedge clk_125_lvds);
        n_checks++;
        if (n_done !== nd0) $display("FAIL bad_pre_done got %0d want %0d", n_done, nd0);
        else n_pass++;
        n_checks++;
        if (good_cnt !== 32'd5 || last_seq !== 8'h60)
            $display("FAIL bad_pre_cnt got good=%0d seq=%h want 5 60", good_cnt, last_seq);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        int nd0;
        nd0 = n_done;
        build(64, 8'h10, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, 20, 1'b0);
        repeat (2) @(negedge clk_125_lvds);
        n_checks++;
        if (n_done !== nd0) $display("FAIL rst_drop got done %0d want %0d", n_done, nd0);
        else n_pass++;
        n_checks++;
        if ({good_cnt, crc_err_cnt, len_err_cnt, pat_err_cnt, last_seq} !== 136'd0)
            $display("FAIL rst_cnts got %0d %0d %0d %0d seq=%h want 0", good_cnt, crc_err_cnt,
                     len_err_cnt, pat_err_cnt, last_seq);
        else n_pass++;
        build(64, 8'h22, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (good_cnt !== 32'd1 || frame_ok !== 1'b1)
            $display("FAIL rst_recover got good=%0d ok=%b want 1 1", good_cnt, frame_ok);
        else n_pass++;
    endtask

    task automatic test_clear;
        build(64, 8'h10, 16'h0800, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b0);
        n_checks++;
        if (pat_err_cnt !== 32'd1) $display("FAIL clr_pre got pat=%0d want 1", pat_err_cnt);
        else n_pass++;
        build(64, 8'h33, 16'h88B5, -1, 8'h00);
        send(7, 8'h55, -1, -1, 1'b1);
        n_checks++;
        if (frame_done !== 1'b1 || frame_ok !== 1'b1)
            $display("FAIL clr_done got done=%b ok=%b want 1 1", frame_done, frame_ok);
        else n_pass++;
        n_checks++;
        if ({good_cnt, crc_err_cnt, len_err_cnt, pat_err_cnt} !== 128'd0)
            $display("FAIL clr_cnts got %0d %0d %0d %0d want all 0", good_cnt, crc_err_cnt,
                     len_err_cnt, pat_err_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc();
        test_len();
        test_pattern();
        test_rx_er();
        test_back_to_back();
        test_bad_preamble();
        test_mid_reset();
        test_clear();
        repeat (2) @(negedge clk_125_lvds);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
